systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Front-end sequencer for the `MATRIX_SIZE`×`MATRIX_SIZE` systolic MAC array.
- Holds operand matrices A and B, loaded one row per write.
- On `start`, clears the array accumulators, then streams A rows into the left edge and B columns into the top edge with the diagonal skew the array needs.
- Drives `acc_en`/`shift_en` for the full wavefront and pulses `done` when every PE holds its final C = A×B element.

## Interface
Parameters:
- `MATRIX_SIZE`, 3, array dimension N (N ≥ 2)
- `DATA_WIDTH`, 8, operand element width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `a_wr_en`  in  1  write `wr_data` into A row `wr_row`
- `b_wr_en`  in  1  write `wr_data` into B row `wr_row`
- `wr_row`  in  $clog2(N)  target row index
- `wr_data`  in  DATA_WIDTH*N  row data; element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `start`  in  1  begin one multiply
- `busy`  out  1  high from CLEAR through DONE
- `done`  out  1  one-cycle completion pulse
- `acc_rst`  out  1  accumulator clear to array
- `acc_en`  out  1  accumulate enable to array
- `shift_en`  out  1  operand shift enable to array
- `left_flat`  out  DATA_WIDTH*N  to array `in_left_flat`; lane i feeds row i
- `top_flat`  out  DATA_WIDTH*N  to array `in_top_flat`; lane j feeds column j

## Operation
- **Storage:** two N×N register banks, A and B, indexed [row][col].
- **Writes:**
  - Writes are accepted only in IDLE.
  - A write with `wr_row` ≥ N is ignored.
  - `a_wr_en` and `b_wr_en` asserted together write the same row of both banks.
- **FSM states:** IDLE, CLEAR, STREAM, DONE.
  - IDLE → CLEAR on `start`.
  - CLEAR → STREAM after 1 cycle; step counter t is set to 0.
  - STREAM: t increments each cycle; → DONE when t = 3N−3.
  - DONE → IDLE after 1 cycle.
  - `start` outside IDLE is ignored.
- **Outputs** are Moore outputs decoded from registered state, t, and the banks. No combinational path from inputs to outputs.
  - CLEAR: `acc_rst`=1; all other outputs 0 except `busy`.
  - STREAM:
    - `acc_en`=`shift_en`=1.
    - Lane i of `left_flat` = A[i][t−i] if 0 ≤ t−i < N, else 0.
    - Lane j of `top_flat` = B[t−j][j] if 0 ≤ t−j < N, else 0.
  - DONE: `done`=1; data lanes 0; enables 0.
  - IDLE: all outputs 0.
- **Counter:** width $clog2(3N−1). t never exceeds 3N−3.
- **Data path:** no arithmetic; operands pass unmodified (sign-agnostic). Zero padding supplies the skew bubbles.
- **Reset:** `rst` at any time, including mid-STREAM, forces IDLE. It also zeros t and both banks, and all outputs read 0 the next cycle. The interrupted multiply is abandoned with no `done`.

## Timing
- `start` sampled high at edge c (state IDLE) gives:
  - CLEAR during cycle c+1.
  - STREAM during cycles c+2 … c+3N−1, t = 0 … 3N−3, which is 3N−2 cycles.
  - DONE during cycle c+3N.
  - IDLE from c+3N+1.
- `busy` is high during cycles c+1 … c+3N.
- Start-to-done latency: 3N cycles (9 for N=3). The next `start` is accepted at the earliest in cycle c+3N+1.
- Write and `start` in the same IDLE cycle: the write lands at that edge, so the stream uses the updated data.
- A is fully injected by t = 2N−2. Cycles t = 2N−1 … 3N−3 carry zeros to let the wavefront reach PE(N−1,N−1).

## Test plan
1. **Reset:** hold `rst` 2 cycles → all outputs 0, `busy`=0; a `start` with no writes streams all zero lanes and `done` lands exactly 9 cycles after `start` (N=3).
2. **Skew schedule:** N=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=[[10,11,12],[13,14,15],[16,17,18]] →
   - t=0: left={1,0,0}, top={10,0,0}.
   - t=2: left={3,5,7}, top={16,14,12}.
   - t=4: left={0,0,9}, top={0,0,18}.
   - t=5–6: lanes all 0.
3. **Integration with array:** same A; B=A → after `done`, array `acc_out`[0][0]=30, [1][1]=81, [2][2]=150, [0][2]=42.
4. **Guards:**
   - A write during STREAM leaves A unchanged.
   - `wr_row`=3 is ignored.
   - `start` during STREAM does not restart or extend the run; `done` still lands 9 cycles after the first `start`.
5. **Mid-operation reset:** assert `rst` at t=2 → next cycle all outputs 0 and banks read 0. No `done` follows. A new load plus `start` completes normally.
6. **Back-to-back:** `start` held high continuously → runs repeat with period 3N+1 = 10 cycles, and `acc_rst` precedes each STREAM.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand sequencer for an NxN systolic MAC array: holds A/B banks and
// streams skewed rows/columns. Ports: write port, start, status, array drive.
module systolic_feeder #(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              a_wr_en,
  input  logic                              b_wr_en,
  input  logic [$clog2(MATRIX_SIZE)-1:0]    wr_row,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] wr_data,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              acc_rst,
  output logic                              acc_en,
  output logic                              shift_en,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] left_flat,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] top_flat
);

  localparam int N    = MATRIX_SIZE;
  localparam int DW   = DATA_WIDTH;
  localparam int TW   = $clog2(3*N-1);
  localparam int LAST = 3*N-3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [DW-1:0] a_q [N][N];
  logic [DW-1:0] a_d [N][N];
  logic [DW-1:0] b_q [N][N];
  logic [DW-1:0] b_d [N][N];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d = S_STREAM;
        t_d     = '0;
      end
      S_STREAM: begin
        if (t_q == TW'(LAST)) state_d = S_DONE;
        else t_d = t_q + 1'b1;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Rows outside 0..N-1 match no r and are dropped.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (state_q == S_IDLE) begin
      for (int r = 0; r < N; r++) begin
        if (32'(wr_row) == r) begin
          for (int k = 0; k < N; k++) begin
            if (a_wr_en) a_d[r][k] = wr_data[k*DW +: DW];
            if (b_wr_en) b_d[r][k] = wr_data[k*DW +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Lane i carries A[i][t-i]; lane j carries B[t-j][j].
  // Any lane with no matching k stays zero, forming the skew bubbles.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    acc_rst   = 1'b0;
    acc_en    = 1'b0;
    shift_en  = 1'b0;
    left_flat = '0;
    top_flat  = '0;
    unique case (state_q)
      S_CLEAR: begin
        busy    = 1'b1;
        acc_rst = 1'b1;
      end
      S_STREAM: begin
        busy     = 1'b1;
        acc_en   = 1'b1;
        shift_en = 1'b1;
        for (int i = 0; i < N; i++) begin
          for (int k = 0; k < N; k++) begin
            if (32'(t_q) == i + k) begin
              left_flat[i*DW +: DW] = a_q[i][k];
              top_flat[i*DW +: DW]  = b_q[k][i];
            end
          end
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=3, 8-bit) with a small
// output-stationary array model fed by the DUT lanes.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_wr_en;
  logic        b_wr_en;
  logic [1:0]  wr_row;
  logic [23:0] wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        acc_rst;
  logic        acc_en;
  logic        shift_en;
  logic [23:0] left_flat;
  logic [23:0] top_flat;

  int checks = 0;
  int errors = 0;

  systolic_feeder #(.MATRIX_SIZE(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_wr_en(a_wr_en), .b_wr_en(b_wr_en),
    .wr_row(wr_row), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done),
    .acc_rst(acc_rst), .acc_en(acc_en), .shift_en(shift_en),
    .left_flat(left_flat), .top_flat(top_flat)
  );

  always #5 clk = ~clk;

  // Array model: PE(i,j) multiplies its left/top inputs and passes them on.
  int          acc [3][3];
  logic [7:0]  ar  [3][3];
  logic [7:0]  br  [3][3];

  function automatic logic [7:0] lin(int i, int j);
    if (j == 0) return left_flat[i*8 +: 8];
    return ar[i][j-1];
  endfunction

  function automatic logic [7:0] tin(int i, int j);
    if (i == 0) return top_flat[j*8 +: 8];
    return br[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (acc_rst) begin
          acc[i][j] <= 0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else if (acc_en) begin
          acc[i][j] <= acc[i][j] + int'(lin(i, j)) * int'(tin(i, j));
          ar[i][j]  <= lin(i, j);
          br[i][j]  <= tin(i, j);
        end
      end
    end
  end

  logic [23:0] exp_l [7] = '{24'h000001, 24'h000402, 24'h070503,
                             24'h080600, 24'h090000, 24'h0, 24'h0};
  logic [23:0] exp_t [7] = '{24'h00000A, 24'h000B0D, 24'h0C0E10,
                             24'h0F1100, 24'h120000, 24'h0, 24'h0};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input bit wa, input bit wb,
                      input logic [1:0] row, input logic [23:0] d);
    a_wr_en = wa;
    b_wr_en = wb;
    wr_row  = row;
    wr_data = d;
    step();
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  task automatic load_ab();
    load(1, 0, 0, 24'h030201);
    load(1, 0, 1, 24'h060504);
    load(1, 0, 2, 24'h090807);
    load(0, 1, 0, 24'h0C0B0A);
    load(0, 1, 1, 24'h0F0E0D);
    load(0, 1, 2, 24'h121110);
  endtask

  task automatic test_reset();
    int n;
    bit nz;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, acc_rst, acc_en, shift_en, left_flat, top_flat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b lanes=%h/%h exp all 0",
               busy, done, left_flat, top_flat);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (acc_rst !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_clear got acc_rst=%b busy=%b exp 1 1", acc_rst, busy);
    end
    n  = 1;
    nz = 0;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
      if (left_flat !== '0 || top_flat !== '0) nz = 1;
    end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL reset_latency got %0d exp 9", n);
    end
    checks++;
    if (nz !== 1'b0) begin
      errors++;
      $display("FAIL reset_zero_lanes got nonzero exp zero");
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_skew();
    load_ab();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (acc_rst !== 1'b1 || acc_en !== 1'b0 || shift_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL skew_clear got rst=%b en=%b sh=%b busy=%b exp 1 0 0 1",
               acc_rst, acc_en, shift_en, busy);
    end
    for (int t = 0; t < 7; t++) begin
      step();
      checks++;
      if (left_flat !== exp_l[t] || top_flat !== exp_t[t]) begin
        errors++;
        $display("FAIL skew_t%0d got left=%h top=%h exp left=%h top=%h",
                 t, left_flat, top_flat, exp_l[t], exp_t[t]);
      end
      checks++;
      if (acc_en !== 1'b1 || shift_en !== 1'b1 || acc_rst !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL skew_en_t%0d got en=%b sh=%b rst=%b done=%b exp 1 1 0 0",
                 t, acc_en, shift_en, acc_rst, done);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || acc_en !== 1'b0 || left_flat !== '0) begin
      errors++;
      $display("FAIL skew_done got done=%b busy=%b en=%b left=%h exp 1 1 0 0",
               done, busy, acc_en, left_flat);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL skew_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_array();
    int n;
    load(0, 1, 0, 24'h030201);
    load(0, 1, 1, 24'h060504);
    load(0, 1, 2, 24'h090807);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL array_latency got %0d exp 9", n);
    end
    checks++;
    if (acc[0][0] !== 30 || acc[1][1] !== 81 || acc[2][2] !== 150 || acc[0][2] !== 42) begin
      errors++;
      $display("FAIL array_acc got %0d %0d %0d %0d exp 30 81 150 42",
               acc[0][0], acc[1][1], acc[2][2], acc[0][2]);
    end
    step();
  endtask

  task automatic test_guards();
    int n;
    bit restarted;
    load(1, 0, 3, 24'h636363);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (left_flat !== 24'h000001) begin
      errors++;
      $display("FAIL guard_t0 got left=%h exp 000001", left_flat);
    end
    a_wr_en = 1'b1;
    wr_row  = 2'd0;
    wr_data = 24'hEEEEEE;
    start   = 1'b1;
    step();
    a_wr_en = 1'b0;
    checks++;
    if (left_flat !== 24'h000402) begin
      errors++;
      $display("FAIL guard_t1 got left=%h exp 000402", left_flat);
    end
    step();
    start = 1'b0;
    checks++;
    if (left_flat !== 24'h070503 || top_flat !== 24'h030507) begin
      errors++;
      $display("FAIL guard_t2 got left=%h top=%h exp 070503 030507",
               left_flat, top_flat);
    end
    n = 4;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL guard_latency got %0d exp 9", n);
    end
    restarted = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (busy !== 1'b0) restarted = 1;
    end
    checks++;
    if (restarted !== 1'b0) begin
      errors++;
      $display("FAIL guard_no_restart got busy after done exp idle");
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit seen;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, acc_rst, acc_en, shift_en, left_flat, top_flat} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got busy=%b en=%b lanes=%h/%h exp all 0",
               busy, acc_en, left_flat, top_flat);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_done got activity after reset exp none");
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n    = 1;
    seen = 0;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
      if (left_flat !== '0 || top_flat !== '0) seen = 1;
    end
    checks++;
    if (seen !== 1'b0 || n !== 9) begin
      errors++;
      $display("FAIL midrst_banks_zero got nonzero=%b latency=%0d exp 0 9", seen, n);
    end
    step();
    load_ab();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    checks++;
    if (left_flat !== exp_l[2] || top_flat !== exp_t[2]) begin
      errors++;
      $display("FAIL midrst_reload got left=%h top=%h exp %h %h",
               left_flat, top_flat, exp_l[2], exp_t[2]);
    end
    n = 4;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL midrst_latency got %0d exp 9", n);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [32:0] m_rst, m_done, m_sh;
    logic [32:0] e_rst, e_done, e_sh;
    int p;
    m_rst = '0; m_done = '0; m_sh = '0;
    e_rst = '0; e_done = '0; e_sh = '0;
    start = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      m_rst[k]  = acc_rst;
      m_done[k] = done;
      m_sh[k]   = shift_en;
      p = (k - 1) % 10 + 1;
      e_rst[k]  = (p == 1);
      e_done[k] = (p == 9);
      e_sh[k]   = (p >= 2 && p <= 8);
    end
    start = 1'b0;
    checks++;
    if (m_rst !== e_rst) begin
      errors++;
      $display("FAIL b2b_acc_rst got %h exp %h", m_rst, e_rst);
    end
    checks++;
    if (m_done !== e_done) begin
      errors++;
      $display("FAIL b2b_done got %h exp %h", m_done, e_done);
    end
    checks++;
    if (m_sh !== e_sh) begin
      errors++;
      $display("FAIL b2b_shift got %h exp %h", m_sh, e_sh);
    end
    p = 0;
    while (busy !== 1'b0 && p < 30) begin
      step();
      p++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got busy=%b exp 0", busy);
    end
  endtask

  initial begin
    rst     = 1'b1;
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
    wr_row  = '0;
    wr_data = '0;
    start   = 1'b0;
    test_reset();
    test_skew();
    test_array();
    test_guards();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
